// File: rtl/music_pkg.sv
// Shared definitions for the music ROM streamer: player state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package music_pkg;

    typedef logic [1:0] state_t;

    // Player states: idle, waiting for a sample tick, ROM read in flight.
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PLAY = 2'd1;
    localparam state_t ST_READ = 2'd2;

endpackage

// File: rtl/music_rom_streamer_if.sv
// Sample output stream between the streamer and its consumer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a sample transfers when out_valid && out_ready.
// Signals: out_data (sample), out_valid (sample pending), out_ready (consumer accepts).
interface music_rom_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/music_rom_sync.sv
// Sample ROM with a registered read address.
// Latency: 1 cycle from addr to q.
// Backpressure: none; reads every cycle.
// Ports: clock, addr (read address), q (data for the address of the previous cycle).
module music_rom_sync #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter     INIT_FILE = "music.mif"
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);
    // Contents come from INIT_FILE through the memory-initialisation flow of
    // the target library; the array itself carries no reset.
    (* rom_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    always_comb begin
        q_d = mem[addr];
    end

    always_ff @(posedge clock) begin
        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/music_rom_streamer.sv
// Streams ROM samples start_addr..end_addr, one per sample_tick, optional looping.
// Latency: sample_tick in cycle N -> out_valid in cycle N+2.
// Backpressure: tick while a sample is unconsumed (or a read is in flight) is dropped and sets sticky overrun.
// Ports: clock/reset (sync, active high), start/stop/loop_en control, start_addr/end_addr range,
//        sample_tick strobe, strm (out_data/out_valid/out_ready), busy, done pulse, overrun.
module music_rom_streamer
    import music_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter     INIT_FILE = "music.mif"
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loop_en,
    input  logic [ADDR_W-1:0]           start_addr,
    input  logic [ADDR_W-1:0]           end_addr,
    input  logic                        sample_tick,
    music_rom_streamer_if.master        strm,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);
    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ADDR_W-1:0] first_q,     first_d;
    logic [ADDR_W-1:0] last_q,      last_d;
    logic              loop_q,      loop_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q,      done_d;
    logic              overrun_q,   overrun_d;

    logic [DATA_W-1:0] rom_q;
    logic [ADDR_W-1:0] addr_next;
    logic              pass_done;

    // addr_q is stable from the PLAY cycle through READ, so the ROM address
    // can be tied straight to it.
    music_rom_sync #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clock (clock),
        .addr  (addr_q),
        .q     (rom_q)
    );

    always_comb begin
        // Address after the current sample, whether played or dropped.
        addr_next = (addr_q == last_q) ? first_q : addr_q + ADDR_W'(1);
        pass_done = (addr_q == last_q) && !loop_q;

        state_d     = state_q;
        addr_d      = addr_q;
        first_d     = first_q;
        last_d      = last_q;
        loop_d      = loop_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        // Consumption clears valid; a sample written this cycle overrides below.
        if (out_valid_q && strm.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (stop) begin
            // Abort: any in-flight read is simply never written out.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_PLAY;
                        addr_d    = start_addr;
                        first_d   = start_addr;
                        last_d    = end_addr;
                        loop_d    = loop_en;
                        overrun_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (sample_tick) begin
                        if (!out_valid_q || strm.out_ready) begin
                            state_d = ST_READ;
                        end else begin
                            // Consumer stalled: skip this sample but keep time.
                            overrun_d = 1'b1;
                            addr_d    = addr_next;
                            if (pass_done) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_READ: begin
                    out_data_d  = rom_q;
                    out_valid_d = 1'b1;
                    addr_d      = addr_next;
                    if (sample_tick) begin
                        overrun_d = 1'b1;
                    end
                    if (pass_done) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            first_q     <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            first_q     <= first_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign strm.out_data  = out_data_q;
    assign strm.out_valid = out_valid_q;
    assign busy           = (state_q == ST_PLAY) || (state_q == ST_READ);
    assign done           = done_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_music_rom_streamer.sv
// Directed bench for music_rom_streamer with a cycle-level reference player.
// Latency: n/a.
// Backpressure: out_ready driven by the stimulus.
module tb_music_rom_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic        sample_tick;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    music_rom_streamer_if #(.DATA_W(8)) strm ();
    assign strm.out_ready = out_ready;

    music_rom_streamer #(
        .ADDR_W    (16),
        .DATA_W    (8),
        .INIT_FILE ("music.mif")
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .sample_tick (sample_tick),
        .strm        (strm),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference player ----------------
    logic [7:0] rom_img [0:65535];
    bit         m_active;    // a pass is running
    bit         m_inflight;  // a tick was accepted; sample lands at the next edge
    int         m_addr, m_first, m_last;
    bit         m_loop;
    logic [7:0] m_data;
    bit         m_valid, m_done, m_overrun;
    int         m_done_cnt = 0;
    logic [7:0] m_log[$];
    bit         cmp_en = 0;

    task automatic load(input int a, input logic [7:0] d);
        rom_img[a] = d;
        dut.u_rom.mem[a] = d;
    endtask

    // Step past the current sample: wrap within the 16-bit space, loop or finish.
    task automatic finish_sample();
        if (m_addr == m_last) begin
            if (m_loop) m_addr = m_first;
            else begin
                m_active = 0;
                m_done   = 1;
                m_done_cnt++;
            end
        end else begin
            m_addr = (m_addr + 1) % 65536;
        end
    endtask

    always @(posedge clk) begin : model
        bit was_valid;
        was_valid = m_valid;
        m_done    = 0;
        if (reset) begin
            m_active = 0; m_inflight = 0; m_addr = 0;
            m_data = 0; m_valid = 0; m_overrun = 0;
            cmp_en = 1;
        end else begin
            if (was_valid && out_ready) m_valid = 0;
            if (stop) begin
                m_active   = 0;
                m_inflight = 0;
            end else if (m_inflight) begin
                m_data     = rom_img[m_addr];
                m_valid    = 1;
                m_inflight = 0;
                m_log.push_back(m_data);
                if (sample_tick) m_overrun = 1;
                finish_sample();
            end else if (m_active) begin
                if (sample_tick) begin
                    if (!was_valid || out_ready) m_inflight = 1;
                    else begin
                        m_overrun = 1;
                        finish_sample();
                    end
                end
            end else if (start) begin
                m_active  = 1;
                m_addr    = start_addr;
                m_first   = start_addr;
                m_last    = end_addr;
                m_loop    = loop_en;
                m_overrun = 0;
            end
        end
    end

    int dut_done_cnt = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_out_valid", strm.out_valid, m_valid);
            chk("cmp_out_data",  strm.out_data,  m_data);
            chk("cmp_busy",      busy,           m_active);
            chk("cmp_done",      done,           m_done);
            chk("cmp_overrun",   overrun,        m_overrun);
            if (done) dut_done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic go(input logic [15:0] sa, input logic [15:0] ea, input logic lp);
        start_addr = sa;
        end_addr   = ea;
        loop_en    = lp;
        start      = 1'b1;
        cyc(1);
        start      = 1'b0;
    endtask

    // Tick in cycle N; returns in cycle N+2 after checking the landed sample.
    task automatic play_tick(input string nm, input logic [7:0] exp);
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        cyc(1);
        chk({nm, "_valid"}, strm.out_valid, 1'b1);
        chk({nm, "_data"},  strm.out_data,  exp);
    endtask

    logic [7:0] seq1 [0:2];
    logic [7:0] seq4 [0:3];
    int d0;

    initial begin
        seq1[0] = 8'h11; seq1[1] = 8'h22; seq1[2] = 8'h33;
        seq4[0] = 8'hA1; seq4[1] = 8'hA2; seq4[2] = 8'hA3; seq4[3] = 8'hA4;

        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start_addr = '0; end_addr = '0; sample_tick = 1'b0; out_ready = 1'b1;
        load(3, 8'h11); load(4, 8'h22); load(5, 8'h33); load(6, 8'h44); load(7, 8'h55);
        load(16'hFFFE, 8'hA1); load(16'hFFFF, 8'hA2); load(0, 8'hA3); load(1, 8'hA4);
        cyc(3);
        chk("rst_out_valid", strm.out_valid, 1'b0);
        chk("rst_out_data",  strm.out_data,  8'h00);
        chk("rst_busy",      busy,           1'b0);
        chk("rst_overrun",   overrun,        1'b0);
        reset = 1'b0;
        cyc(1);

        // Single non-looping pass 3..5.
        m_log.delete();
        d0 = dut_done_cnt;
        go(16'd3, 16'd5, 1'b0);
        chk("s1_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            play_tick("s1", seq1[i]);
            chk("s1_done_now", done, (i == 2) ? 1'b1 : 1'b0);
            chk("s1_busy_now", busy, (i == 2) ? 1'b0 : 1'b1);
            cyc(2);
        end
        chk("s1_done_count", dut_done_cnt - d0, 1);
        chk("s1_model_len", m_log.size(), 3);
        for (int i = 0; i < 3; i++) chk("s1_model_seq", m_log[i], seq1[i]);

        // Looping pass; loop_en dropped mid-pass must not matter.
        m_log.delete();
        d0 = dut_done_cnt;
        go(16'd3, 16'd5, 1'b1);
        loop_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            play_tick("s2", seq1[i % 3]);
            cyc(2);
        end
        chk("s2_no_done", dut_done_cnt - d0, 0);
        chk("s2_busy", busy, 1'b1);
        chk("s2_model_len", m_log.size(), 7);
        chk("s2_model_last", m_log[6], 8'h11);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("s2_stop_idle", busy, 1'b0);

        // Backpressure: two dropped ticks advance the address.
        go(16'd3, 16'd7, 1'b0);
        play_tick("s3_first", 8'h11);
        out_ready = 1'b0;
        cyc(2);
        for (int i = 0; i < 2; i++) begin
            sample_tick = 1'b1; cyc(1); sample_tick = 1'b0; cyc(3);
        end
        chk("s3_overrun",    overrun,        1'b1);
        chk("s3_hold_data",  strm.out_data,  8'h11);
        chk("s3_hold_valid", strm.out_valid, 1'b1);
        out_ready = 1'b1;
        cyc(2);
        play_tick("s3_after_skip", 8'h44);
        chk("s3_overrun_sticky", overrun, 1'b1);
        stop = 1'b1; cyc(1); stop = 1'b0;
        go(16'd3, 16'd5, 1'b0);
        chk("s3_overrun_cleared", overrun, 1'b0);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // Wrap-around range FFFE..0001.
        m_log.delete();
        d0 = dut_done_cnt;
        go(16'hFFFE, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            play_tick("s4", seq4[i]);
            cyc(2);
        end
        chk("s4_done_count", dut_done_cnt - d0, 1);
        chk("s4_model_len", m_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("s4_model_seq", m_log[i], seq4[i]);

        // Stop during READ: sample discarded, no done.
        d0 = dut_done_cnt;
        go(16'd3, 16'd5, 1'b0);
        play_tick("s5_first", 8'h11);
        cyc(2);
        sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("s5_busy",  busy,           1'b0);
        chk("s5_valid", strm.out_valid, 1'b0);
        chk("s5_data",  strm.out_data,  8'h11);
        cyc(2);
        chk("s5_no_late_valid", strm.out_valid, 1'b0);
        chk("s5_no_done", dut_done_cnt - d0, 0);
        start_addr = 16'd3; end_addr = 16'd5;
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        chk("s5_start_stop_idle", busy, 1'b0);
        cyc(2);
        chk("s5_still_idle", busy, 1'b0);

        // Tick during READ is dropped but the in-flight sample still lands.
        go(16'd3, 16'd5, 1'b0);
        sample_tick = 1'b1; cyc(2); sample_tick = 1'b0;
        chk("s7_data",    strm.out_data, 8'h11);
        chk("s7_overrun", overrun,       1'b1);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // Reset during READ.
        go(16'd3, 16'd5, 1'b0);
        play_tick("s6_first", 8'h11);
        sample_tick = 1'b1; cyc(1); sample_tick = 1'b0;
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("s6_valid",   strm.out_valid, 1'b0);
        chk("s6_data",    strm.out_data,  8'h00);
        chk("s6_busy",    busy,           1'b0);
        chk("s6_overrun", overrun,        1'b0);
        chk("s6_done",    done,           1'b0);
        cyc(2);
        chk("s6_no_sample", strm.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/music_rom_streamer.md
MUSIC_ROM_STREAMER -- requirements
Module: music_rom_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, sample width.
REQ-003 SHALL have parameter INIT_FILE, default "music.mif", ROM contents file passed to the ROM sub-module.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin playback (sampled only in IDLE).
REQ-007 SHALL have port stop  input  1  abort playback.
REQ-008 SHALL have port loop_en  input  1  restart at start_addr after end_addr instead of finishing.
REQ-009 SHALL have port start_addr  input  ADDR_W  first sample address, latched on accepted start.
REQ-010 SHALL have port end_addr  input  ADDR_W  last sample address, latched on accepted start.
REQ-011 SHALL have port sample_tick  input  1  one-cycle sample-rate strobe.
REQ-012 SHALL have port out_data  output  DATA_W  current sample.
REQ-013 SHALL have port out_valid  output  1  out_data holds an unconsumed sample.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-015 SHALL have port busy  output  1  high in PLAY or READ.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a non-looping pass completes.
REQ-017 SHALL have port overrun  output  1  sticky; a sample tick was dropped.

Function
REQ-018 SHALL implement states IDLE, PLAY, READ.
REQ-019 IDLE: start && !stop -> PLAY; addr <= start_addr; latch start_addr/end_addr/loop_en; clear overrun.
REQ-020 PLAY: sample_tick with (!out_valid || out_ready) -> drive ROM address = addr, go READ.
REQ-021 PLAY: sample_tick with out_valid && !out_ready -> set overrun, no read, advance addr per REQ-024 rules, stay PLAY.
REQ-022 READ: ROM q valid (1-cycle synchronous ROM); out_data <= q, out_valid <= 1 at end of READ cycle.
REQ-023 Latency: sample_tick in cycle N -> out_valid high in cycle N+2.
REQ-024 Address advance: if addr == end_addr: loop_en -> addr <= start_addr, PLAY; else -> IDLE, done pulse; otherwise addr <= addr+1 (mod 2^ADDR_W) -> PLAY.
REQ-025 end_addr < start_addr SHALL play through wrap-around (addr wraps to 0); end_addr == start_addr plays one sample per pass.
REQ-026 sample_tick in READ SHALL be dropped and set overrun.
REQ-027 out_valid SHALL clear on out_valid && out_ready unless a new sample is written in the same cycle (write wins).
REQ-028 stop in any state SHALL go IDLE next cycle; pending READ discarded; no done pulse; out_valid/out_data unaffected.
REQ-029 start && stop in the same cycle: stop wins; start while busy ignored.
REQ-030 loop_en changes mid-pass SHALL have no effect until the next accepted start.

Reset
REQ-031 reset SHALL force IDLE, addr=0, out_data=0, out_valid=0, busy=0, done=0, overrun=0.
REQ-032 reset mid-READ SHALL discard the in-flight sample; reset dominates start and stop.

Structure
REQ-033 State enum SHALL reside in shared package music_pkg.
REQ-034 ROM SHALL be sub-module music_rom_sync (ADDR_W, DATA_W, INIT_FILE; registered-address read, 1-cycle latency).
REQ-035 Expected size 150-300 lines RTL including sub-module.

Verification
REQ-036 ROM[3..5]=0x11,0x22,0x33; start_addr=3, end_addr=5, loop_en=0, out_ready=1, tick every 4 cycles -> out_data 0x11,0x22,0x33 each 2 cycles after its tick; done pulse once; busy falls.
REQ-037 Same with loop_en=1, 7 ticks -> 0x11,0x22,0x33,0x11,0x22,0x33,0x11; no done.
REQ-038 out_ready=0 after first sample, 2 more ticks -> overrun=1, out_data stays 0x11, addr advanced; next start clears overrun.
REQ-039 start_addr=0xFFFE, end_addr=0x0001 -> reads 0xFFFE,0xFFFF,0x0000,0x0001 then done.
REQ-040 stop asserted in READ cycle -> IDLE next cycle, out_valid unchanged, no done; start+stop together from IDLE -> stays IDLE.
REQ-041 reset in READ -> all outputs 0 next cycle, no sample emitted.
